// File: rtl/result_write_arbiter_if.sv
// Requester-side handshake bus: NUM_REQ producers offering one word each per cycle.
// The master side holds data stable while valid is high and ready is low.
interface result_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
);
  logic [NUM_REQ-1:0]       valid;
  logic [NUM_REQ*WIDTH-1:0] data;
  logic [NUM_REQ-1:0]       ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/result_write_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ word producers into the single write port
// of the result storage, tracking the fill level and sequencing storage clears.
module result_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int WORDS   = 8192,
  parameter int CNT_W   = $clog2(WORDS) + 1,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  result_write_arbiter_if.slave    req,
  input  logic                     clear,
  output logic [WIDTH-1:0]         store_din,
  output logic                     store_we,
  output logic                     store_addr_reset,
  output logic [CNT_W-1:0]         word_count,
  output logic                     full,
  output logic [IDX_W-1:0]         last_src
);

  typedef enum logic [1:0] {RUN, CLR, FULL_ST} state_t;

  localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]   word_count_reg, word_count_next;
  logic               full_reg, full_next;
  logic               store_we_reg;
  logic               store_addr_reset_reg;
  logic [WIDTH-1:0]   store_din_reg;
  logic [IDX_W-1:0]   last_src_reg;

  logic [WIDTH-1:0]   data_word [NUM_REQ];
  logic [IDX_W:0]     cand_sum  [NUM_REQ];
  logic [IDX_W-1:0]   cand_idx  [NUM_REQ];
  logic               grant_en;
  logic               found;
  logic               xfer;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant;

  // Candidate k is the requester k positions after the round-robin pointer.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign data_word[gi] = req.data[gi*WIDTH +: WIDTH];
      assign cand_sum[gi]  = {1'b0, rr_ptr_reg} + (IDX_W+1)'(gi);
      assign cand_idx[gi]  = (cand_sum[gi] >= (IDX_W+1)'(NUM_REQ))
                             ? IDX_W'(cand_sum[gi] - (IDX_W+1)'(NUM_REQ))
                             : cand_sum[gi][IDX_W-1:0];
    end
  endgenerate

  assign grant_en = (state_reg == RUN) && !clear && (word_count_reg < WORDS_C);

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req.valid[cand_idx[k]]) begin
        found     = 1'b1;
        grant_idx = cand_idx[k];
      end
    end
    xfer  = found && grant_en;
    grant = xfer ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
  end

  assign req.ready = grant;

  always_comb begin
    state_next      = state_reg;
    word_count_next = word_count_reg;
    rr_ptr_next     = rr_ptr_reg;
    if (xfer) begin
      word_count_next = word_count_reg + 1'b1;
      rr_ptr_next     = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
    case (state_reg)
      RUN: begin
        if (clear)
          state_next = CLR;
        else if (xfer && word_count_next == WORDS_C)
          state_next = FULL_ST;
      end
      FULL_ST: begin
        if (clear)
          state_next = CLR;
      end
      CLR: begin
        // The storage address is being reset this cycle, so the count follows it.
        word_count_next = '0;
        if (!clear)
          state_next = RUN;
      end
      default: state_next = RUN;
    endcase
    full_next = (word_count_next == WORDS_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg            <= RUN;
      rr_ptr_reg           <= '0;
      word_count_reg       <= '0;
      full_reg             <= 1'b0;
      store_we_reg         <= 1'b0;
      store_addr_reset_reg <= 1'b0;
      store_din_reg        <= '0;
      last_src_reg         <= '0;
    end else begin
      state_reg            <= state_next;
      rr_ptr_reg           <= rr_ptr_next;
      word_count_reg       <= word_count_next;
      full_reg             <= full_next;
      store_we_reg         <= xfer;
      store_addr_reset_reg <= (state_next == CLR);
      if (xfer) begin
        store_din_reg <= data_word[grant_idx];
        last_src_reg  <= grant_idx;
      end
    end
  end

  assign store_din        = store_din_reg;
  assign store_we         = store_we_reg;
  assign store_addr_reset = store_addr_reset_reg;
  assign word_count       = word_count_reg;
  assign full             = full_reg;
  assign last_src         = last_src_reg;

endmodule

// File: tb/tb_result_write_arbiter.sv
// Directed bench: a large-capacity instance for arbitration/clear/reset behaviour and a
// 4-word instance for the full/back-pressure path, both fed from the same stimulus.
module tb_result_write_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         clear;
  logic [3:0]   valid;
  logic [31:0]  word [4];
  int           checks = 0;
  int           errors = 0;

  result_write_arbiter_if #(.NUM_REQ(4), .WIDTH(32)) bus_a ();
  result_write_arbiter_if #(.NUM_REQ(4), .WIDTH(32)) bus_b ();

  logic [31:0] a_din,  b_din;
  logic        a_we,   b_we;
  logic        a_ar,   b_ar;
  logic [13:0] a_cnt;
  logic [2:0]  b_cnt;
  logic        a_full, b_full;
  logic [1:0]  a_src,  b_src;

  assign bus_a.valid = valid;
  assign bus_b.valid = valid;
  assign bus_a.data  = {word[3], word[2], word[1], word[0]};
  assign bus_b.data  = {word[3], word[2], word[1], word[0]};

  result_write_arbiter #(.NUM_REQ(4), .WIDTH(32), .WORDS(8192)) dut_a (
    .clk(clk), .reset(reset), .req(bus_a), .clear(clear),
    .store_din(a_din), .store_we(a_we), .store_addr_reset(a_ar),
    .word_count(a_cnt), .full(a_full), .last_src(a_src)
  );

  result_write_arbiter #(.NUM_REQ(4), .WIDTH(32), .WORDS(4)) dut_b (
    .clk(clk), .reset(reset), .req(bus_b), .clear(clear),
    .store_din(b_din), .store_we(b_we), .store_addr_reset(b_ar),
    .word_count(b_cnt), .full(b_full), .last_src(b_src)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && a_we)
      $display("write src=%0d din=%08h count=%0d", a_src, a_din, a_cnt);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    valid = 4'h0;
    word[0] = 32'hC0DE0000;
    word[1] = 32'hC0DE0001;
    word[2] = 32'hC0DE0002;
    word[3] = 32'hC0DE0003;
    repeat (2) @(posedge clk);
    settle();
    chk("rst_we",    a_we,        1'b0);
    chk("rst_ar",    a_ar,        1'b0);
    chk("rst_din",   a_din,       32'h0);
    chk("rst_cnt",   a_cnt,       14'd0);
    chk("rst_full",  a_full,      1'b0);
    chk("rst_src",   a_src,       2'd0);
    chk("rst_ready", bus_a.ready, 4'h0);

    // All four requesters valid for 8 cycles: grants rotate 0,1,2,3,0,1,2,3.
    tick();
    reset = 1'b0;
    valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("rr_ready", bus_a.ready, 64'(4'b0001 << (k % 4)));
      chk("rr_cnt",   a_cnt,       64'(k));
      chk("rr_we",    a_we,        64'(k != 0));
      if (k != 0) begin
        chk("rr_din", a_din, 64'(32'hC0DE0000 + (k - 1) % 4));
        chk("rr_src", a_src, 64'((k - 1) % 4));
      end
      tick();
    end
    valid = 4'h0;
    settle();
    chk("rr_last_we",  a_we,        1'b1);
    chk("rr_last_din", a_din,       32'hC0DE0003);
    chk("rr_cnt8",     a_cnt,       14'd8);
    chk("rr_idle_rdy", bus_a.ready, 4'h0);
    tick();
    settle();
    chk("idle_we",   a_we,  1'b0);
    chk("idle_din",  a_din, 32'hC0DE0003);
    chk("idle_src",  a_src, 2'd3);

    // Lone requester 2, then 0 and 3 competing with the pointer at 3.
    tick();
    word[2] = 32'hDEADBEEF;
    valid   = 4'b0100;
    settle();
    chk("solo_ready", bus_a.ready, 4'b0100);
    tick();
    valid = 4'b1001;
    settle();
    chk("solo_we",    a_we,        1'b1);
    chk("solo_din",   a_din,       32'hDEADBEEF);
    chk("solo_src",   a_src,       2'd2);
    chk("solo_cnt",   a_cnt,       14'd9);
    chk("ptr3_ready", bus_a.ready, 4'b1000);
    tick();
    settle();
    chk("ptr0_ready", bus_a.ready, 4'b0001);
    chk("ptr0_din",   a_din,       32'hC0DE0003);
    chk("ptr0_cnt",   a_cnt,       14'd10);
    tick();
    valid = 4'h0;
    settle();
    chk("wrap_src", a_src, 2'd0);
    chk("wrap_cnt", a_cnt, 14'd11);

    // CLEAR raised the cycle after a grant: that word still writes, then the clear.
    tick();
    valid = 4'b0010;
    settle();
    chk("pre_clr_ready", bus_a.ready, 4'b0010);
    tick();
    clear = 1'b1;
    settle();
    chk("clr_ready", bus_a.ready, 4'h0);
    chk("clr_we",    a_we,        1'b1);
    chk("clr_din",   a_din,       32'hC0DE0001);
    chk("clr_cnt",   a_cnt,       14'd12);
    chk("clr_ar0",   a_ar,        1'b0);
    tick();
    clear = 1'b0;
    settle();
    chk("clrst_ar",    a_ar,        1'b1);
    chk("clrst_we",    a_we,        1'b0);
    chk("clrst_ready", bus_a.ready, 4'h0);
    chk("clrst_cnt",   a_cnt,       14'd12);
    tick();
    settle();
    chk("post_clr_cnt",   a_cnt,       14'd0);
    chk("post_clr_ar",    a_ar,        1'b0);
    chk("post_clr_ready", bus_a.ready, 4'b0010);

    // RESET while streaming at WORD_COUNT=5.
    tick();
    valid = 4'hF;
    settle();
    chk("strm_cnt",   a_cnt,       14'd1);
    chk("strm_src",   a_src,       2'd1);
    chk("strm_ready", bus_a.ready, 4'b0100);
    repeat (4) tick();
    reset = 1'b1;
    settle();
    chk("strm_cnt5", a_cnt, 14'd5);
    tick();
    reset = 1'b0;
    settle();
    chk("mid_rst_we",    a_we,        1'b0);
    chk("mid_rst_cnt",   a_cnt,       14'd0);
    chk("mid_rst_din",   a_din,       32'h0);
    chk("mid_rst_src",   a_src,       2'd0);
    chk("mid_rst_full",  a_full,      1'b0);
    chk("mid_rst_ready", bus_a.ready, 4'b0001);
    tick();
    valid = 4'h0;
    settle();
    chk("first_we",  a_we,  1'b1);
    chk("first_din", a_din, 32'hC0DE0000);
    chk("first_cnt", a_cnt, 14'd1);

    // 4-word instance: requester 0 streams, only 4 words accepted.
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    valid = 4'b0001;
    for (int k = 0; k < 7; k++) begin
      settle();
      chk("fill_ready", bus_b.ready, 64'(k < 4 ? 4'b0001 : 4'b0000));
      chk("fill_cnt",   b_cnt,       64'(k < 4 ? k : 4));
      chk("fill_we",    b_we,        64'(k >= 1 && k <= 4));
      chk("fill_full",  b_full,      64'(k >= 4));
      tick();
    end
    chk("fill_din", b_din, 32'hC0DE0000);

    // CLEAR pulse while full.
    clear = 1'b1;
    settle();
    chk("fclr_ready", bus_b.ready, 4'h0);
    chk("fclr_full",  b_full,      1'b1);
    chk("fclr_cnt",   b_cnt,       3'd4);
    tick();
    clear = 1'b0;
    settle();
    chk("fclrst_ar",   b_ar,  1'b1);
    chk("fclrst_we",   b_we,  1'b0);
    chk("fclrst_full", b_full, 1'b1);
    tick();
    settle();
    chk("resume_cnt",   b_cnt,       3'd0);
    chk("resume_full",  b_full,      1'b0);
    chk("resume_ar",    b_ar,        1'b0);
    chk("resume_ready", bus_b.ready, 4'b0001);
    tick();
    valid = 4'h0;
    settle();
    chk("resume_we",  b_we,  1'b1);
    chk("resume_cnt1", b_cnt, 3'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
